// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared constants, types and hazard helper for stall_ctrl
// Purpose : constants shared by the hazard controller and its mult/div busy timer.
// Contents: TUSE_NONE marker, default mult/div busy lengths, busy counter type,
//           stall source record and the single-operand RAW hazard compare.
package stall_ctrl_pkg;

  // Tuse value meaning "this operand is not read by the D-stage instruction".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Default busy lengths of the shared multiply/divide unit (cycles, 1..15).
  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

  localparam int unsigned MD_CNT_W = 4;
  typedef logic [MD_CNT_W-1:0] md_cnt_t;

  // Individual stall causes, kept separate so each can be observed on its own.
  typedef struct packed {
    logic rs;
    logic rt;
    logic md;
  } stall_src_t;

  // RAW hazard for one source operand against one in-flight producer.
  // Register $0 never matches, and an operand needed no sooner than the
  // producer's result becomes forwardable (tuse >= tnew) does not stall.
  function automatic logic raw_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] dst,
    input logic [1:0] tnew
  );
    return (src != 5'd0) && (tuse != TUSE_NONE) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_timer.sv
// rtl/stall_ctrl_md_busy_timer.sv - busy countdown for the shared multiply/divide unit
// Purpose : loads MULT_CYC or DIV_CYC on an accepted start, counts down to zero,
//           reports busy while non-zero and flags a start issued while busy.
// Ports   : clk, reset (async active-low)
//           md_start  in  start pulse from the E stage
//           md_div    in  qualifies md_start: 1 = divide, 0 = multiply
//           md_busy   out registered busy flag (counter non-zero)
//           md_err    out sticky: start seen while busy
module stall_ctrl_md_busy_timer
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy,
  output logic md_err
);

  md_cnt_t cnt_q, cnt_d;
  logic    md_busy_q, md_busy_d;
  logic    md_err_q, md_err_d;

  always_comb begin
    cnt_d    = cnt_q;
    md_err_d = md_err_q;
    if (md_start && !md_busy_q) begin
      cnt_d = md_div ? md_cnt_t'(DIV_CYC) : md_cnt_t'(MULT_CYC);
    end else if (cnt_q != '0) begin
      // A start arriving while busy is dropped; the running operation keeps
      // its original end time.
      cnt_d = cnt_q - md_cnt_t'(1);
    end
    if (md_start && md_busy_q) begin
      md_err_d = 1'b1;
    end
    // Busy is registered alongside the counter so it equals (cnt_q != 0)
    // without a decode path after the flop.
    md_busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
      md_err_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
      md_err_q  <= md_err_d;
    end
  end

  assign md_busy = md_busy_q;
  assign md_err  = md_err_q;

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline hazard/stall controller for the 5-stage core
// Purpose : drives F/D register write enables and the E-register bubble from RAW
//           hazards (Tuse vs Tnew) and mult/div unit occupancy; counts stall cycles.
// Ports   : clk, reset (async active-low)
//           D_rs, D_rt, D_Tuse_rs, D_Tuse_rt   D-stage operands and their Tuse
//           E_A3, E_Tnew, M_A3, M_Tnew         producers in E and M
//           D_is_md, E_md_start, E_md_div      mult/div usage and start
//           F_WE, D_WE, E_clr, M_WE, W_WE      pipeline register controls
//           md_busy, stall_cnt, md_err         status / performance outputs
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        D_is_md,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        F_WE,
  output logic        D_WE,
  output logic        E_clr,
  output logic        M_WE,
  output logic        W_WE,
  output logic        md_busy,
  output logic [31:0] stall_cnt,
  output logic        md_err
);

  stall_src_t  src;
  logic        stall;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  stall_ctrl_md_busy_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .md_start (E_md_start),
    .md_div   (E_md_div),
    .md_busy  (md_busy),
    .md_err   (md_err)
  );

  always_comb begin
    src.rs = raw_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew) |
             raw_hazard(D_rs, D_Tuse_rs, M_A3, M_Tnew);
    src.rt = raw_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew) |
             raw_hazard(D_rt, D_Tuse_rt, M_A3, M_Tnew);
    // E_md_start is included so the start cycle itself holds off a HI/LO user,
    // since md_busy only rises after that edge.
    src.md = D_is_md & (md_busy | E_md_start);
    stall  = src.rs | src.rt | src.md;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign F_WE      = ~stall;
  assign D_WE      = ~stall;
  assign E_clr     = stall;
  assign M_WE      = 1'b1;
  assign W_WE      = 1'b1;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - self-checking bench for stall_ctrl
module tb_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_is_md, E_md_start, E_md_div;
  logic        F_WE, D_WE, E_clr, M_WE, W_WE, md_busy, md_err;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  stall_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_Tuse_rs  (D_Tuse_rs),
    .D_Tuse_rt  (D_Tuse_rt),
    .E_A3       (E_A3),
    .M_A3       (M_A3),
    .E_Tnew     (E_Tnew),
    .M_Tnew     (M_Tnew),
    .D_is_md    (D_is_md),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .F_WE       (F_WE),
    .D_WE       (D_WE),
    .E_clr      (E_clr),
    .M_WE       (M_WE),
    .W_WE       (W_WE),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt),
    .md_err     (md_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] e_a3, m_a3;
    logic [1:0] e_tnew, m_tnew;
    logic       is_md;
    logic       exp_stall;
  } vec_t;

  function automatic vec_t mk(string n, int rs, int rt, int tuse_rs, int tuse_rt,
                              int e_a3, int m_a3, int e_tnew, int m_tnew,
                              int is_md, int exp_stall);
    vec_t v;
    v.name = n;
    v.rs = 5'(rs);         v.rt = 5'(rt);
    v.tuse_rs = 2'(tuse_rs); v.tuse_rt = 2'(tuse_rt);
    v.e_a3 = 5'(e_a3);     v.m_a3 = 5'(m_a3);
    v.e_tnew = 2'(e_tnew); v.m_tnew = 2'(m_tnew);
    v.is_md = 1'(is_md);   v.exp_stall = 1'(exp_stall);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected {F_WE, D_WE, E_clr, M_WE, W_WE} for a given stall value.
  function automatic logic [31:0] ctl_exp(input logic s);
    return {27'd0, ~s, ~s, s, 1'b1, 1'b1};
  endfunction

  function automatic logic [31:0] ctl_act();
    return {27'd0, F_WE, D_WE, E_clr, M_WE, W_WE};
  endfunction

  task automatic quiet();
    D_rs = 0; D_rt = 0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
    E_A3 = 0; M_A3 = 0; E_Tnew = 0; M_Tnew = 0;
    D_is_md = 0; E_md_start = 0; E_md_div = 0;
  endtask

  task automatic apply(input vec_t v);
    D_rs = v.rs; D_rt = v.rt; D_Tuse_rs = v.tuse_rs; D_Tuse_rt = v.tuse_rt;
    E_A3 = v.e_a3; M_A3 = v.m_a3; E_Tnew = v.e_tnew; M_Tnew = v.m_tnew;
    D_is_md = v.is_md;
  endtask

  // Advance one active edge and settle 2 time units after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  vec_t vecs[12];
  int   exp_cnt;

  initial begin
    vecs[0]  = mk("raw_e_stall",    8, 0, 1, 3, 8, 0, 2, 0, 0, 1);
    vecs[1]  = mk("raw_e_ready",    8, 0, 1, 3, 8, 0, 1, 0, 0, 0);
    vecs[2]  = mk("reg0_e",         0, 0, 0, 3, 0, 0, 2, 0, 0, 0);
    vecs[3]  = mk("raw_m_rt",       0, 9, 3, 0, 0, 9, 0, 1, 0, 1);
    vecs[4]  = mk("tuse_none",      8, 0, 3, 3, 8, 0, 3, 0, 0, 0);
    vecs[5]  = mk("tnew_zero",      8, 8, 0, 0, 8, 8, 0, 0, 0, 0);
    vecs[6]  = mk("reg_mismatch",   5, 7, 0, 0, 6, 4, 2, 2, 0, 0);
    vecs[7]  = mk("raw_e_rt",       0, 12, 3, 1, 12, 0, 2, 0, 0, 1);
    vecs[8]  = mk("raw_m_rs",       3, 0, 1, 3, 0, 3, 0, 2, 0, 1);
    vecs[9]  = mk("tuse_eq_tnew",   3, 0, 2, 3, 0, 3, 0, 2, 0, 0);
    vecs[10] = mk("md_idle",        0, 0, 3, 3, 0, 0, 0, 0, 1, 0);
    vecs[11] = mk("reg0_m",         0, 0, 3, 0, 0, 0, 0, 2, 0, 0);

    quiet();
    reset = 1'b0;
    #1;
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_md_err", 32'(md_err), 32'd0);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_ctl", ctl_act(), ctl_exp(1'b0));

    // Single-cycle hazard vectors, each held across one edge.
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i]);
      #1;
      chk(vecs[i].name, ctl_act(), ctl_exp(vecs[i].exp_stall));
      if (vecs[i].exp_stall) exp_cnt++;
      step();
    end
    quiet();
    #1;
    chk("table_stall_cnt", stall_cnt, 32'(exp_cnt));

    // Multiply: start at edge t, D_is_md stalls from the start cycle through t+5.
    E_md_start = 1; E_md_div = 0; D_is_md = 1;
    #1;
    chk("mult_start_cycle_stall", ctl_act(), ctl_exp(1'b1));
    step();
    E_md_start = 0;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("mult_busy_k%0d", k), 32'(md_busy), 32'(k <= 5));
      chk($sformatf("mult_stall_k%0d", k), ctl_act(), ctl_exp(k <= 5));
      step();
    end
    D_is_md = 0;
    chk("mult_no_err", 32'(md_err), 32'd0);

    // Divide with a second start while busy: ignored, error flagged.
    E_md_start = 1; E_md_div = 1;
    step();
    E_md_start = 0;
    for (int k = 1; k <= 11; k++) begin
      chk($sformatf("div_busy_k%0d", k), 32'(md_busy), 32'(k <= 10));
      if (k == 2) begin
        E_md_start = 1; E_md_div = 0;
      end
      step();
      E_md_start = 0;
    end
    chk("div_md_err", 32'(md_err), 32'd1);

    // Reset asserted mid-divide with cnt=7.
    E_md_start = 1; E_md_div = 1;
    step();
    E_md_start = 0;
    step();
    step();
    step();
    chk("pre_rst_busy", 32'(md_busy), 32'd1);
    chk("pre_rst_err", 32'(md_err), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_busy", 32'(md_busy), 32'd0);
    chk("async_rst_cnt", stall_cnt, 32'd0);
    chk("async_rst_err", 32'(md_err), 32'd0);
    step();
    reset = 1'b1;
    #1;
    chk("post_rst_ctl", ctl_act(), ctl_exp(1'b0));
    step();
    chk("post_rst_busy", 32'(md_busy), 32'd0);

    // Hold a stall for 20 edges.
    apply(vecs[0]);
    for (int k = 0; k < 20; k++) step();
    quiet();
    #1;
    chk("stall_cnt_20", stall_cnt, 32'd20);

    // Saturation near the top of the counter.
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    apply(vecs[0]);
    step();
    chk("stall_cnt_sat1", stall_cnt, 32'hFFFF_FFFF);
    step();
    step();
    quiet();
    #1;
    chk("stall_cnt_sat3", stall_cnt, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
